icap_fifo_sequencer: RTL

- Drains the 8-bit first-word-fall-through configuration byte FIFO into the Virtex-5 ICAP port.
- Packs bytes into 32-bit words, optionally bit-swaps each byte, and strobes ICAP CE/WRITE once per word.
- Runs a byte-counted transfer on start; handles FIFO underrun timeout, ICAP busy stalls and abort, and flushes the FIFO on error.
- Sits between the host-side FIFO writer and the ICAP primitive in the port_icap path.

---
 rtl/icap_fifo_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/icap_fifo_sequencer.sv
// icap_fifo_sequencer: drains an 8-bit FWFT byte FIFO into the Virtex-5 ICAP as 32-bit words,
// with a byte-counted transfer, underrun timeout, busy stall, abort and FIFO flush on error.
module icap_fifo_sequencer #(
    parameter bit         SWAP_BITS    = 1'b1,
    parameter logic [7:0] PAD_BYTE     = 8'h00,
    parameter int         TIMEOUT      = 1024,
    parameter int         FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] length,
    input  logic        abort,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_en_out,
    output logic        fifo_flush,
    input  logic        icap_busy,
    output logic        icap_ce_n,
    output logic        icap_wr_n,
    output logic [31:0] icap_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);
    typedef enum logic [2:0] {IDLE, FILL, WRITE, DONE, FLUSH} state_t;
    state_t      state, state_nx;
    logic [15:0] remaining, stall;
    logic [1:0]  byte_idx;
    logic [23:0] word;
    logic [31:0] padded;
    logic [7:0]  flush_cnt;
    logic        zero_done, pop, strobe, accept;

    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[i ^ 7];
        return SWAP_BITS ? r : w;
    endfunction

    // first byte of a word always lands in [31:24]; lanes not yet filled take PAD_BYTE
    assign padded = byte_idx == 2'd0 ? {fifo_data, {3{PAD_BYTE}}} :
                    byte_idx == 2'd1 ? {word[7:0], fifo_data, {2{PAD_BYTE}}} :
                    byte_idx == 2'd2 ? {word[15:0], fifo_data, PAD_BYTE} : {word, fifo_data};
    assign accept      = state == IDLE && start && length != 16'd0;
    assign fifo_en_out = pop;
    assign icap_ce_n   = !strobe;
    assign icap_wr_n   = !strobe;
    assign busy        = state != IDLE;
    assign done        = state == DONE || zero_done;

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        strobe     = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            IDLE:  state_nx = accept ? FILL : IDLE;
            FILL: begin
                pop = !abort && !fifo_empty;
                if (abort)
                    state_nx = FLUSH;
                else if (pop && (remaining == 16'd1 || byte_idx == 2'd3))
                    state_nx = WRITE;
                else if (fifo_empty && stall == 16'(TIMEOUT - 1))
                    state_nx = FLUSH;
            end
            WRITE: begin
                strobe = !abort && !icap_busy;
                if (abort)
                    state_nx = FLUSH;
                else if (strobe)
                    state_nx = remaining == 16'd0 ? DONE : FILL;
            end
            DONE:  state_nx = IDLE;
            FLUSH: begin
                fifo_flush = 1'b1;
                state_nx   = flush_cnt == 8'(FLUSH_CYCLES - 1) ? DONE : FLUSH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            remaining     <= 16'd0;
            stall         <= 16'd0;
            byte_idx      <= 2'd0;
            word          <= 24'd0;
            flush_cnt     <= 8'd0;
            zero_done     <= 1'b0;
            error         <= 1'b0;
            words_written <= 16'd0;
            icap_data     <= 32'd0;
        end else begin
            state     <= state_nx;
            zero_done <= state == IDLE && start && length == 16'd0;
            stall     <= state == FILL && fifo_empty ? stall + 16'd1 : 16'd0;
            flush_cnt <= state == FLUSH ? flush_cnt + 8'd1 : 8'd0;
            if (accept) begin
                remaining     <= length;
                byte_idx      <= 2'd0;
                error         <= 1'b0;
                words_written <= 16'd0;
            end
            if (pop) begin
                word      <= {word[15:0], fifo_data};
                remaining <= remaining - 16'd1;
                byte_idx  <= byte_idx + 2'd1;
                if (state_nx == WRITE)
                    icap_data <= lane_swap(padded);
            end
            if (strobe)
                words_written <= words_written + 16'd1;
            if (state != FLUSH && state_nx == FLUSH)
                error <= 1'b1;
        end
    end
endmodule
